// File: rtl/icache_fetcher.sv
// Instruction fetch stage with a direct-mapped, one-instruction-per-line cache
// in front of the program-memory port; exports saturating hit/miss counters.
module icache_fetcher #(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
  parameter int unsigned CACHE_LINES           = 16,
  parameter int unsigned COUNTER_BITS          = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNTER_BITS-1:0]          hit_count,
  output logic [COUNTER_BITS-1:0]          miss_count
);

  localparam int unsigned IDX_BITS = $clog2(CACHE_LINES);
  localparam int unsigned TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;
  // A cache covering the whole address space has no tag bits; keep one constant-zero bit.
  localparam int unsigned TAG_W    = (TAG_BITS == 0) ? 1 : TAG_BITS;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_FETCHING = 3'b001,
    ST_FETCHED  = 3'b010
  } state_t;

  state_t                             state_q;
  logic                               mem_valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   mem_addr_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   instr_q;
  logic [COUNTER_BITS-1:0]            hit_q;
  logic [COUNTER_BITS-1:0]            miss_q;

  logic [CACHE_LINES-1:0]             line_valid_q;
  logic [TAG_W-1:0]                   line_tag_q  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0]   line_data_q [CACHE_LINES];

  logic [IDX_BITS-1:0]                lk_idx;
  logic [TAG_W-1:0]                   lk_tag;
  logic                               lk_hit;
  logic [IDX_BITS-1:0]                fill_idx;
  logic [TAG_W-1:0]                   fill_tag;

  // Lookup decodes the live pc; the fill reuses the latched request address.
  always_comb begin
    lk_idx   = IDX_BITS'(current_pc);
    lk_tag   = TAG_W'(current_pc >> IDX_BITS);
    lk_hit   = line_valid_q[lk_idx] && (line_tag_q[lk_idx] == lk_tag) && !flush;
    fill_idx = IDX_BITS'(mem_addr_q);
    fill_tag = TAG_W'(mem_addr_q >> IDX_BITS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      instr_q      <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      line_valid_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (lk_hit) begin
              instr_q <= line_data_q[lk_idx];
              state_q <= ST_FETCHED;
              if (hit_q != '1) hit_q <= hit_q + COUNTER_BITS'(1);
            end else begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= current_pc;
              state_q     <= ST_FETCHING;
              if (miss_q != '1) miss_q <= miss_q + COUNTER_BITS'(1);
            end
          end
        end
        ST_FETCHING: begin
          if (mem_read_ready) begin
            mem_valid_q            <= 1'b0;
            instr_q                <= mem_read_data;
            state_q                <= ST_FETCHED;
            line_valid_q[fill_idx] <= 1'b1;
            line_tag_q[fill_idx]   <= fill_tag;
            line_data_q[fill_idx]  <= mem_read_data;
          end
        end
        ST_FETCHED: begin
          if (core_state == CORE_DECODE) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      // Placed last so a flush overrides a same-cycle fill's valid bit.
      if (flush) line_valid_q <= '0;
    end
  end

  assign mem_read_valid   = mem_valid_q;
  assign mem_read_address = mem_addr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;
  assign hit_count        = hit_q;
  assign miss_count       = miss_q;

endmodule

// File: tb/tb_icache_fetcher.sv
// Bench for icache_fetcher: directed fetch sequences, a responsive memory,
// and a cycle model of the fetch/cache rules compared every cycle.
module tb_icache_fetcher;

  localparam int LINES = 16;
  localparam int CMAX  = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        flush_main = 1'b0;
  logic        flush_fill = 1'b0;
  logic        flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data  = 16'h0;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [3:0]  hit_count;
  logic [3:0]  miss_count;

  assign flush = flush_main | flush_fill;

  always #5 clk = ~clk;

  icache_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16),
    .CACHE_LINES(LINES),
    .COUNTER_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_state(core_state),
    .current_pc(current_pc),
    .flush(flush),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state),
    .instruction(instruction),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program memory and responder: answers the mem_lat-th cycle a request is seen.
  logic [15:0] prog [256];
  int  mem_lat       = 3;
  int  rsp_cnt       = 0;
  bit  stray_ready   = 1'b0;
  bit  flush_on_fill = 1'b0;

  always @(negedge clk) begin
    if (mem_read_valid === 1'b1) rsp_cnt = rsp_cnt + 1;
    else rsp_cnt = 0;
    mem_read_ready = ((mem_read_valid === 1'b1) && (rsp_cnt == mem_lat)) || stray_ready;
    mem_read_data  = (mem_read_valid === 1'b1) ? prog[mem_read_address] : 16'hDEAD;
    flush_fill     = flush_on_fill && (mem_read_valid === 1'b1) && mem_read_ready;
  end

  // Behavioural model: state 0=IDLE 1=FETCHING 2=FETCHED, cache as idx/tag arrays.
  int m_state = 0, m_valid = 0, m_addr = 0, m_instr = 0, m_hit = 0, m_miss = 0;
  int lv [LINES];
  int lt [LINES];
  int ld [LINES];
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    int idx, tg, pc;
    if (reset) begin
      m_state = 0; m_valid = 0; m_addr = 0; m_instr = 0; m_hit = 0; m_miss = 0;
      for (int i = 0; i < LINES; i++) lv[i] = 0;
      chk_en = 1'b1;
    end else begin
      pc = int'(current_pc);
      if (m_state == 0 && core_state == 3'b001) begin
        idx = pc % LINES;
        tg  = pc / LINES;
        if (!flush && lv[idx] == 1 && lt[idx] == tg) begin
          m_instr = ld[idx];
          m_state = 2;
          m_hit   = (m_hit < CMAX) ? m_hit + 1 : CMAX;
        end else begin
          m_valid = 1;
          m_addr  = pc;
          m_state = 1;
          m_miss  = (m_miss < CMAX) ? m_miss + 1 : CMAX;
        end
      end else if (m_state == 1 && mem_read_ready) begin
        m_valid = 0;
        m_instr = int'(mem_read_data);
        m_state = 2;
        idx = m_addr % LINES;
        lv[idx] = 1;
        lt[idx] = m_addr / LINES;
        ld[idx] = int'(mem_read_data);
      end else if (m_state == 2 && core_state == 3'b010) begin
        m_state = 0;
      end
      if (flush) for (int i = 0; i < LINES; i++) lv[i] = 0;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(fetcher_state), 32'(m_state));
      chk("req_valid", 32'(mem_read_valid), 32'(m_valid));
      if (m_valid == 1) chk("req_addr", 32'(mem_read_address), 32'(m_addr));
      chk("instr", 32'(instruction), 32'(m_instr));
      chk("hits", 32'(hit_count), 32'(m_hit));
      chk("misses", 32'(miss_count), 32'(m_miss));
    end
  end

  // Start a fetch, then scramble pc/core_state until FETCHED (bounded).
  task automatic fetch(input logic [7:0] pc, output int cycles, output int vcycles,
                       output logic [7:0] last_addr);
    @(negedge clk);
    core_state = 3'b001;
    current_pc = pc;
    cycles = 0; vcycles = 0; last_addr = 8'h00;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      core_state = 3'b011;
      current_pc = ~pc;
      if (mem_read_valid === 1'b1) begin
        vcycles++;
        last_addr = mem_read_address;
      end
      if (fetcher_state === 3'b010) break;
    end
    if (fetcher_state !== 3'b010) chk("fetch_timeout", 32'(fetcher_state), 32'd2);
  endtask

  task automatic decode();
    @(negedge clk);
    core_state = 3'b010;
    @(negedge clk);
    core_state = 3'b000;
    chk("decode_to_idle", 32'(fetcher_state), 32'd0);
  endtask

  initial begin
    int cyc, vcyc;
    logic [7:0] la;
    reset = 1'b1; core_state = 3'b000; current_pc = 8'h00;
    for (int i = 0; i < 256; i++) prog[i] = 16'h1000 + 16'(i);
    prog[8'h05] = 16'h3A12;
    prog[8'h15] = 16'hBEEF;
    prog[8'h07] = 16'h7777;
    prog[8'h09] = 16'h9999;

    repeat (2) @(negedge clk);
    chk("rst_state", 32'(fetcher_state), 32'd0);
    chk("rst_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_addr", 32'(mem_read_address), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_counts", {24'd0, hit_count, miss_count}, 32'd0);
    reset = 1'b0;

    // Cold miss with 3-cycle memory.
    fetch(8'h05, cyc, vcyc, la);
    chk("cold_latency", 32'(cyc), 32'd4);
    chk("cold_req_cycles", 32'(vcyc), 32'd3);
    chk("cold_req_addr", 32'(la), 32'h05);
    chk("cold_instr", 32'(instruction), 32'h3A12);
    chk("cold_miss_count", 32'(miss_count), 32'd1);
    decode();

    // Hit on the same pc.
    fetch(8'h05, cyc, vcyc, la);
    chk("hit_latency", 32'(cyc), 32'd1);
    chk("hit_no_req", 32'(vcyc), 32'd0);
    chk("hit_instr", 32'(instruction), 32'h3A12);
    chk("hit_count", 32'(hit_count), 32'd1);
    decode();

    // Conflict: 0x15 evicts 0x05 from line 5.
    fetch(8'h15, cyc, vcyc, la);
    chk("conf_a_req", 32'(vcyc), 32'd3);
    chk("conf_a_instr", 32'(instruction), 32'hBEEF);
    decode();
    fetch(8'h05, cyc, vcyc, la);
    chk("conf_b_req", 32'(vcyc), 32'd3);
    chk("conf_b_addr", 32'(la), 32'h05);
    chk("conf_b_instr", 32'(instruction), 32'h3A12);
    chk("conf_miss_count", 32'(miss_count), 32'd3);
    decode();

    // Flush pulse invalidates a primed line.
    fetch(8'h07, cyc, vcyc, la);
    decode();
    @(negedge clk); flush_main = 1'b1;
    @(negedge clk); flush_main = 1'b0;
    fetch(8'h07, cyc, vcyc, la);
    chk("flush_miss_req", 32'(vcyc), 32'd3);
    chk("flush_instr", 32'(instruction), 32'h7777);
    decode();

    // Flush coinciding with the fill: delivered, but not cached.
    flush_on_fill = 1'b1;
    fetch(8'h09, cyc, vcyc, la);
    flush_on_fill = 1'b0;
    chk("flushfill_instr", 32'(instruction), 32'h9999);
    decode();
    fetch(8'h09, cyc, vcyc, la);
    chk("flushfill_refetch_req", 32'(vcyc), 32'd3);
    chk("flushfill_miss_count", 32'(miss_count), 32'd7);
    decode();

    // Reset while a long request is outstanding.
    mem_lat = 10;
    @(negedge clk); core_state = 3'b001; current_pc = 8'h20;
    @(negedge clk); core_state = 3'b000;
    @(negedge clk);
    chk("midmiss_req_up", 32'(mem_read_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midmiss_withdrawn", 32'(mem_read_valid), 32'd0);
    chk("midmiss_idle", 32'(fetcher_state), 32'd0);
    chk("midmiss_counts", {24'd0, hit_count, miss_count}, 32'd0);
    reset = 1'b0;
    stray_ready = 1'b1;
    @(negedge clk); stray_ready = 1'b0;
    @(negedge clk);
    chk("stray_ready_ignored", 32'(fetcher_state), 32'd0);
    chk("stray_instr_kept", 32'(instruction), 32'd0);
    mem_lat = 3;
    fetch(8'h05, cyc, vcyc, la);
    chk("post_reset_miss_req", 32'(vcyc), 32'd3);
    chk("post_reset_miss_count", 32'(miss_count), 32'd1);
    decode();

    // Saturation and FETCHED hold under a non-DECODE core state.
    for (int k = 0; k < 20; k++) begin
      fetch(8'h05, cyc, vcyc, la);
      if (k == 0) begin
        repeat (3) @(negedge clk);
        chk("hold_fetched", 32'(fetcher_state), 32'd2);
      end
      decode();
    end
    chk("sat_hit_count", 32'(hit_count), 32'd15);
    chk("sat_model_hits", 32'(m_hit), 32'd15);
    chk("sat_miss_count", 32'(miss_count), 32'd1);
    chk("sat_model_misses", 32'(m_miss), 32'd1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_fetcher.md
Name: icache_fetcher

Overview:
- Per-core instruction fetch stage, directly upstream of the core scheduler.
- When the scheduler enters FETCH, the block returns the 16-bit instruction at current_pc and reports FETCHED on fetcher_state.
- A small direct-mapped instruction cache (one instruction per line) sits in front of the program-memory controller port, so loop bodies avoid repeated memory round-trips.
- Hit/miss counters are exported for performance bring-up.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, program address width; equals the current_pc width.
- PROGRAM_MEM_DATA_BITS, 16, instruction width.
- CACHE_LINES, 16, number of lines; power of two, 2..2^PROGRAM_MEM_ADDR_BITS.
- COUNTER_BITS, 16, width of the hit/miss counters.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- core_state  input  3  scheduler state (IDLE=000, FETCH=001, DECODE=010, others ignored).
- current_pc  input  PROGRAM_MEM_ADDR_BITS  address to fetch.
- flush  input  1  invalidate all cache lines.
- mem_read_valid  output  1  program-memory read request.
- mem_read_address  output  PROGRAM_MEM_ADDR_BITS  request address.
- mem_read_ready  input  1  memory response strobe, one cycle.
- mem_read_data  input  PROGRAM_MEM_DATA_BITS  response data, valid with mem_read_ready.
- fetcher_state  output  3  IDLE=000, FETCHING=001, FETCHED=010.
- instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction, stable while FETCHED.
- hit_count  output  COUNTER_BITS  saturating lookup-hit count.
- miss_count  output  COUNTER_BITS  saturating lookup-miss count.

Behaviour:
- Address split: idx = current_pc[log2(CACHE_LINES)-1:0]; tag = the remaining upper bits. Each line holds valid, tag and data.
- Reset:
  - fetcher_state=IDLE; mem_read_valid=0; mem_read_address=0; instruction=0; both counters=0.
  - All valid bits cleared.
  - Reset during FETCHING withdraws the request: mem_read_valid is 0 on the next cycle, and the response is ignored.
- IDLE:
  - Lookup occurs only when core_state==FETCH.
  - Hit (valid[idx] and tag match, and flush=0): next cycle instruction=line data, fetcher_state=FETCHED, hit_count+1. Hit latency is 1 cycle.
  - Miss: next cycle mem_read_valid=1, mem_read_address=current_pc, fetcher_state=FETCHING, miss_count+1.
  - Lookup with flush=1 in the same cycle counts as a miss.
- FETCHING:
  - mem_read_valid and mem_read_address are held constant until mem_read_ready=1.
  - On ready: next cycle mem_read_valid=0, instruction=mem_read_data, fetcher_state=FETCHED, and the line at idx is written (valid=1, tag, data).
  - Miss latency is memory latency + 1 cycle to FETCHED.
  - mem_read_ready outside FETCHING is ignored.
- FETCHED:
  - instruction and fetcher_state are held until core_state==DECODE, then fetcher_state=IDLE next cycle.
  - instruction keeps its value in IDLE; it is not cleared.
- flush:
  - Clears all valid bits in the cycle it is sampled, in any state.
  - If flush coincides with a fill write, flush wins: the line is not marked valid, but the instruction is still delivered to FETCHED.
  - flush never aborts an outstanding memory request.
- Conflict: a different tag at the same idx replaces the line on fill (no associativity).
- Counters saturate at all-ones; they do not wrap.
- current_pc is sampled only at lookup. Later changes while FETCHING or FETCHED are ignored.
- core_state values other than FETCH (in IDLE) and DECODE (in FETCHED) cause no transition.

Test Plan:
1. Cold miss: after reset, core_state=FETCH with pc=0x05; memory answers 3 cycles later with 0x3A12.
   - mem_read_valid=1, addr=0x05 for 3 cycles.
   - FETCHED with instruction=0x3A12; miss_count=1.
   - core_state=DECODE leads to IDLE.
2. Hit: re-fetch pc=0x05.
   - No mem_read_valid.
   - FETCHED 1 cycle after FETCH with 0x3A12; hit_count=1.
3. Conflict (CACHE_LINES=16): fetch 0x15 (memory returns 0xBEEF), then 0x05.
   - Both miss; memory is requested for 0x05 again; miss_count increments by 2.
4. Flush: prime pc=0x07, pulse flush, fetch 0x07 → miss.
   - Also assert flush in the same cycle as a fill: the instruction is delivered, and the next fetch of that pc misses.
5. Reset mid-miss: reset while FETCHING.
   - Next cycle mem_read_valid=0, fetcher_state=IDLE, counters=0.
   - A subsequent mem_read_ready is ignored, and all lines miss.
6. Saturation (COUNTER_BITS=4): 20 hits on one pc → hit_count=15.
   - State is held in FETCHED until DECODE, even with core_state=EXECUTE.
